ov7670_sleep_ctrl: RTL and testbench
====================================

Name: ov7670_sleep_ctrl

Overview:
- Runtime power-down / wake-up sequencer for the OV7670. It is the counterpart to the power-up controller, which releases reset and reports `power_done`.
- On a user sleep request, it waits for a frame boundary, drives PWDN high and waits for the sensor to settle before acknowledging.
- On a wake request, it releases PWDN and waits the wake settle time before reporting the camera ready again.
- Sensor registers survive PWDN, so no SCCB re-init is needed.

Parameters:
- `DELAY_PWDN`, 50_000: cycles PWDN is held before `sleep_ack` (1 ms at 50 MHz).
- `DELAY_WAKE`, 150_000: cycles after PWDN release before `cam_ready` (3 ms at 50 MHz).
- `DRAIN_TIMEOUT`, 2_500_000: maximum cycles spent waiting for a frame boundary (50 ms).
- `CNT_W`, 25: width of the shared delay counter. Must hold the largest of the three parameters.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `power_done` in 1: level from the power-up controller; 1 = sensor powered and out of reset.
- `cam_vsync` in 1: camera VSYNC, already synchronised to `clk`.
- `sleep_req` in 1: one-cycle request to enter sleep.
- `wake_req` in 1: one-cycle request to leave sleep.
- `ov7670_pwdn` out 1: sensor PWDN pin, 1 = powered down.
- `cam_ready` out 1: 1 only while the sensor is streaming and usable.
- `sleep_ack` out 1: one-cycle pulse when sleep has been reached.
- `wake_done` out 1: one-cycle pulse when wake-up completes.
- `busy` out 1: 1 in DRAIN, SLEEP_SETTLE and WAKE_SETTLE.

Behaviour:
- All state is synchronous to `clk`. `rst` is sampled on the rising edge.
- Reset values:
  - state = WAIT_INIT; counter = 0; `vsync_d` = 0; `wake_pend` = 0.
  - `ov7670_pwdn` = 0, `cam_ready` = 0, `sleep_ack` = 0, `wake_done` = 0, `busy` = 0.
- All outputs are registered.
- Frame boundary: rising edge of `cam_vsync`, i.e. `cam_vsync`=1 and `vsync_d`=0. `vsync_d` is the previous-cycle copy of `cam_vsync`.
- States and transitions:
  - WAIT_INIT: `pwdn`=0, `cam_ready`=0. Go to ACTIVE when `power_done`=1. `sleep_req` and `wake_req` are ignored here.
  - ACTIVE: `pwdn`=0, `cam_ready`=1.
    - `sleep_req` → DRAIN, counter cleared.
    - `wake_req` is ignored.
    - If `sleep_req` and `wake_req` arrive together, the sleep request is taken.
  - DRAIN: `pwdn`=0, `cam_ready`=0, counter increments.
    - Frame boundary → SLEEP_SETTLE.
    - Counter = `DRAIN_TIMEOUT`−1 → SLEEP_SETTLE (forced, so a dead sensor cannot hang the block).
    - `wake_req` → back to ACTIVE (abort) with no `sleep_ack`. Abort has priority over the boundary in the same cycle.
  - SLEEP_SETTLE: `pwdn`=1, counter increments from 0.
    - At counter = `DELAY_PWDN`−1 → ASLEEP and pulse `sleep_ack` for one cycle.
    - A `wake_req` received here sets `wake_pend`; settling is never cut short.
  - ASLEEP: `pwdn`=1, `busy`=0.
    - `wake_req` or `wake_pend`=1 → WAKE_SETTLE. `wake_pend` is cleared and the counter cleared.
    - `sleep_req` is ignored.
  - WAKE_SETTLE: `pwdn`=0, counter increments.
    - At counter = `DELAY_WAKE`−1 → ACTIVE and pulse `wake_done` for one cycle.
    - `sleep_req` here is ignored; it is not queued.
- Latencies:
  - `pwdn` rises exactly 1 cycle after the boundary cycle is sampled.
  - `sleep_ack` occurs `DELAY_PWDN` cycles after `pwdn` rises.
  - `cam_ready` rises `DELAY_WAKE`+1 cycles after `pwdn` falls.
  - `cam_ready` falls 1 cycle after `sleep_req` is sampled.
- Supply loss: `power_done`=0 in any state except WAIT_INIT → WAIT_INIT next cycle. Effects:
  - `pwdn`=0 and `cam_ready`=0 next cycle.
  - Counter and `wake_pend` cleared.
  - No `sleep_ack` or `wake_done` pulse is issued.
- `rst` mid-sequence returns everything to reset values in the next cycle, including `pwdn`=0.
- Counter is `CNT_W` bits and is never allowed to wrap; each state exits at its terminal count.
- `sleep_ack` and `wake_done` are never high in the same cycle, and each is never high two cycles in a row.

Test Plan:
- Params `DELAY_PWDN`=4, `DELAY_WAKE`=6, `DRAIN_TIMEOUT`=20. Reset; raise `power_done` at cycle 3 → `cam_ready`=1 at cycle 5; `pwdn` stays 0 throughout.
- From ACTIVE, pulse `sleep_req`, then a VSYNC rise 5 cycles later → `cam_ready` falls the next cycle; `pwdn`=1 one cycle after the rise; `sleep_ack` pulses exactly 4 cycles later; `busy`=0 in ASLEEP.
- Sleep with `cam_vsync` held at 0 → timeout after 20 DRAIN cycles; `pwdn` rises and `sleep_ack` follows 4 cycles later.
- In ASLEEP, pulse `wake_req` → `pwdn`=0 the next cycle; `wake_done` pulses and `cam_ready`=1 after 6 settle cycles.
- `wake_req` during SLEEP_SETTLE → `sleep_ack` pulses, then WAKE_SETTLE is entered with no further request; `wake_req` during DRAIN → ACTIVE, with no `pwdn` pulse and no `sleep_ack`.
- Drop `power_done` mid-SLEEP_SETTLE → `pwdn`=0 and `cam_ready`=0 next cycle with no pulses. Separately, assert `rst` mid-WAKE_SETTLE → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ov7670_sleep_ctrl.sv
// Runtime power-down / wake-up sequencer for the OV7670: drains to a frame
// boundary, holds PWDN through a settle time, and re-settles on wake.
module ov7670_sleep_ctrl #(
  parameter int DELAY_PWDN    = 50_000,
  parameter int DELAY_WAKE    = 150_000,
  parameter int DRAIN_TIMEOUT = 2_500_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic power_done,
  input  logic cam_vsync,
  input  logic sleep_req,
  input  logic wake_req,
  output logic ov7670_pwdn,
  output logic cam_ready,
  output logic sleep_ack,
  output logic wake_done,
  output logic busy
);

  localparam logic [CNT_W-1:0] PWDN_LAST  = CNT_W'(DELAY_PWDN - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(DELAY_WAKE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    ACTIVE,
    DRAIN,
    SLEEP_SETTLE,
    ASLEEP,
    WAKE_SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             vsync_d;
  logic             wake_pend, wake_pend_nxt;
  logic             pwdn_nxt, ready_nxt, ack_nxt, done_nxt, busy_nxt;
  logic             boundary;

  assign boundary = cam_vsync & ~vsync_d;

  always_comb begin
    state_nxt     = state;
    wake_pend_nxt = wake_pend;
    case (state)
      WAIT_INIT: if (power_done) state_nxt = ACTIVE;
      ACTIVE:    if (sleep_req) state_nxt = DRAIN;
      DRAIN: begin
        // Abort wins over a boundary seen in the same cycle.
        if (wake_req)                            state_nxt = ACTIVE;
        else if (boundary || cnt == DRAIN_LAST)  state_nxt = SLEEP_SETTLE;
      end
      SLEEP_SETTLE: begin
        if (wake_req)         wake_pend_nxt = 1'b1;
        if (cnt == PWDN_LAST) state_nxt = ASLEEP;
      end
      ASLEEP: begin
        if (wake_req || wake_pend) begin
          state_nxt     = WAKE_SETTLE;
          wake_pend_nxt = 1'b0;
        end
      end
      WAKE_SETTLE: if (cnt == WAKE_LAST) state_nxt = ACTIVE;
      default:     state_nxt = WAIT_INIT;
    endcase

    if (state != WAIT_INIT && !power_done) begin
      state_nxt     = WAIT_INIT;
      wake_pend_nxt = 1'b0;
    end

    // The counter restarts from zero on every state change.
    cnt_nxt = (state_nxt == state) ? cnt + 1'b1 : '0;
    if (state_nxt == WAIT_INIT || state_nxt == ACTIVE || state_nxt == ASLEEP)
      cnt_nxt = '0;

    pwdn_nxt  = (state_nxt == SLEEP_SETTLE) || (state_nxt == ASLEEP);
    // Ready only once ACTIVE has been occupied for a full cycle.
    ready_nxt = (state == ACTIVE) && (state_nxt == ACTIVE);
    ack_nxt   = (state == SLEEP_SETTLE) && (state_nxt == ASLEEP);
    done_nxt  = (state == WAKE_SETTLE) && (state_nxt == ACTIVE);
    busy_nxt  = (state_nxt == DRAIN) || (state_nxt == SLEEP_SETTLE) ||
                (state_nxt == WAKE_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_INIT;
      cnt         <= '0;
      vsync_d     <= 1'b0;
      wake_pend   <= 1'b0;
      ov7670_pwdn <= 1'b0;
      cam_ready   <= 1'b0;
      sleep_ack   <= 1'b0;
      wake_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      vsync_d     <= cam_vsync;
      wake_pend   <= wake_pend_nxt;
      ov7670_pwdn <= pwdn_nxt;
      cam_ready   <= ready_nxt;
      sleep_ack   <= ack_nxt;
      wake_done   <= done_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ov7670_sleep_ctrl.sv
// Directed bench for ov7670_sleep_ctrl; expected outputs {pwdn,ready,ack,done,busy}
// are queued with each stimulus step and compared after the following clock edge.
module tb_ov7670_sleep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic power_done = 1'b0;
  logic cam_vsync = 1'b0;
  logic sleep_req = 1'b0;
  logic wake_req = 1'b0;
  logic ov7670_pwdn, cam_ready, sleep_ack, wake_done, busy;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  string      tag_q[$];

  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] READY = 5'b01000;
  localparam logic [4:0] BUSY  = 5'b00001;
  localparam logic [4:0] PDB   = 5'b10001;
  localparam logic [4:0] ACK   = 5'b10100;
  localparam logic [4:0] SLEEP = 5'b10000;
  localparam logic [4:0] DONE  = 5'b00010;

  ov7670_sleep_ctrl #(
    .DELAY_PWDN(4),
    .DELAY_WAKE(6),
    .DRAIN_TIMEOUT(20),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power_done(power_done),
    .cam_vsync(cam_vsync),
    .sleep_req(sleep_req),
    .wake_req(wake_req),
    .ov7670_pwdn(ov7670_pwdn),
    .cam_ready(cam_ready),
    .sleep_ack(sleep_ack),
    .wake_done(wake_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic sr, input logic wr,
                      input logic [4:0] exp, input string tag);
    logic [4:0] obs, want;
    string      t;
    rst       = r;
    sleep_req = sr;
    wake_req  = wr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs  = {ov7670_pwdn, cam_ready, sleep_ack, wake_done, busy};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, want);
    end
    sleep_req = 1'b0;
    wake_req  = 1'b0;
  endtask

  task automatic idle(input int n, input logic [4:0] exp, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and power-up
    step(1'b1, 1'b0, 1'b0, IDLE, "reset");
    step(1'b1, 1'b0, 1'b0, IDLE, "reset_hold");
    idle(2, IDLE, "wait_init");
    step(1'b0, 1'b1, 1'b1, IDLE, "wait_init_ignores_req");
    power_done = 1'b1;
    step(1'b0, 1'b0, 1'b0, IDLE, "enter_active");
    idle(2, READY, "active");
    step(1'b0, 1'b0, 1'b1, READY, "active_ignores_wake");

    // Sleep via VSYNC boundary
    step(1'b0, 1'b1, 1'b0, BUSY, "drain_entry");
    idle(4, BUSY, "drain");
    cam_vsync = 1'b1;
    step(1'b0, 1'b0, 1'b0, PDB, "boundary_pwdn");
    idle(3, PDB, "sleep_settle");
    step(1'b0, 1'b0, 1'b0, ACK, "sleep_ack");
    step(1'b0, 1'b1, 1'b0, SLEEP, "asleep_ignores_sleep");
    idle(1, SLEEP, "asleep");

    // Wake, with a sleep request during settle that must not queue
    step(1'b0, 1'b0, 1'b1, BUSY, "wake_entry");
    step(1'b0, 1'b1, 1'b0, BUSY, "wake_settle_ignores_sleep");
    idle(4, BUSY, "wake_settle");
    step(1'b0, 1'b0, 1'b0, DONE, "wake_done");
    idle(2, READY, "ready_after_wake");

    // Drain timeout with VSYNC stuck low
    cam_vsync = 1'b0;
    step(1'b0, 1'b1, 1'b0, BUSY, "timeout_drain_entry");
    idle(19, BUSY, "timeout_drain");
    step(1'b0, 1'b0, 1'b0, PDB, "timeout_pwdn");
    idle(3, PDB, "timeout_settle");
    step(1'b0, 1'b0, 1'b0, ACK, "timeout_ack");
    step(1'b0, 1'b0, 1'b1, BUSY, "timeout_wake_entry");
    idle(5, BUSY, "timeout_wake_settle");
    step(1'b0, 1'b0, 1'b0, DONE, "timeout_wake_done");
    idle(1, READY, "timeout_ready");

    // Wake request during SLEEP_SETTLE is remembered
    step(1'b0, 1'b1, 1'b0, BUSY, "pend_drain");
    cam_vsync = 1'b1;
    step(1'b0, 1'b0, 1'b0, PDB, "pend_pwdn");
    step(1'b0, 1'b0, 1'b1, PDB, "pend_wake_in_settle");
    idle(2, PDB, "pend_settle");
    step(1'b0, 1'b0, 1'b0, ACK, "pend_ack");
    step(1'b0, 1'b0, 1'b0, BUSY, "pend_auto_wake");
    idle(5, BUSY, "pend_wake_settle");
    step(1'b0, 1'b0, 1'b0, DONE, "pend_wake_done");
    idle(1, READY, "pend_ready");

    // Wake during DRAIN aborts, even with a coincident boundary
    cam_vsync = 1'b0;
    step(1'b0, 1'b1, 1'b0, BUSY, "abort_drain");
    idle(2, BUSY, "abort_drain_wait");
    cam_vsync = 1'b1;
    step(1'b0, 1'b0, 1'b1, IDLE, "abort_to_active");
    idle(2, READY, "abort_ready");

    // Supply loss mid SLEEP_SETTLE
    cam_vsync = 1'b0;
    step(1'b0, 1'b1, 1'b0, BUSY, "loss_drain");
    cam_vsync = 1'b1;
    step(1'b0, 1'b0, 1'b0, PDB, "loss_pwdn");
    idle(1, PDB, "loss_settle");
    power_done = 1'b0;
    step(1'b0, 1'b0, 1'b0, IDLE, "loss_drop");
    idle(3, IDLE, "loss_no_pulse");
    cam_vsync  = 1'b0;
    power_done = 1'b1;
    step(1'b0, 1'b0, 1'b0, IDLE, "loss_repower");
    idle(1, READY, "loss_ready");

    // Reset mid WAKE_SETTLE
    step(1'b0, 1'b1, 1'b0, BUSY, "rst_drain");
    cam_vsync = 1'b1;
    step(1'b0, 1'b0, 1'b0, PDB, "rst_pwdn");
    idle(3, PDB, "rst_settle");
    step(1'b0, 1'b0, 1'b0, ACK, "rst_ack");
    cam_vsync = 1'b0;
    step(1'b0, 1'b0, 1'b1, BUSY, "rst_wake_entry");
    idle(2, BUSY, "rst_wake_settle");
    step(1'b1, 1'b0, 1'b0, IDLE, "rst_mid_wake");
    step(1'b0, 1'b0, 1'b0, IDLE, "rst_release");
    idle(2, READY, "rst_ready");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
